// File: rtl/bpred_fetch_mems.sv
// Branch-predictor fetch-stage memories: a 256x32 instruction RAM and a 256x36 BTB/bimodal RAM
// with four 9-bit write lanes. Both are simple dual-port with a registered, read-old-data read.
module bpred_fetch_mems #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned LANE_W = 9,
  parameter int unsigned LANES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      insn_wren_i,
  input  logic [ADDR_W-1:0]         insn_wraddr_i,
  input  logic [INSN_W-1:0]         insn_data_i,
  input  logic [ADDR_W-1:0]         insn_rdaddr_i,
  output logic [INSN_W-1:0]         insn_q_o,

  input  logic                      btb_wren_i,
  input  logic [LANES-1:0]          btb_byteena_i,
  input  logic [ADDR_W-1:0]         btb_wraddr_i,
  input  logic [LANES*LANE_W-1:0]   btb_data_i,
  input  logic [ADDR_W-1:0]         btb_rdaddr_i,
  output logic [LANES*LANE_W-1:0]   btb_q_o
);

  localparam int unsigned BtbW = LANES * LANE_W;

  // Zero-initialised at configuration time; reset never touches the arrays.
  logic [INSN_W-1:0] insn_mem_q [DEPTH] = '{default: '0};
  logic [BtbW-1:0]   btb_mem_q  [DEPTH] = '{default: '0};

  logic [INSN_W-1:0] insn_rd_q;
  logic [BtbW-1:0]   btb_rd_q;

  // Writes are honoured regardless of reset so the predictor can sweep-clear during reset.
  always_ff @(posedge clk) begin
    if (insn_wren_i) begin
      insn_mem_q[insn_wraddr_i] <= insn_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_wren_i) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (btb_byteena_i[i]) begin
          btb_mem_q[btb_wraddr_i][i*LANE_W +: LANE_W] <= btb_data_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Non-blocking array update means a same-edge read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      insn_rd_q <= '0;
      btb_rd_q  <= '0;
    end else begin
      insn_rd_q <= insn_mem_q[insn_rdaddr_i];
      btb_rd_q  <= btb_mem_q[btb_rdaddr_i];
    end
  end

  assign insn_q_o = insn_rd_q;
  assign btb_q_o  = btb_rd_q;

endmodule

// File: tb/tb_bpred_fetch_mems.sv
// Directed self-checking bench for bpred_fetch_mems: expected read data is computed from a
// reference memory model, queued when a read is issued and compared one edge later.
module tb_bpred_fetch_mems;

  logic        clk;
  logic        reset;
  logic        insn_wren;
  logic [7:0]  insn_wraddr;
  logic [31:0] insn_data;
  logic [7:0]  insn_rdaddr;
  logic [31:0] insn_q;
  logic        btb_wren;
  logic [3:0]  btb_byteena;
  logic [7:0]  btb_wraddr;
  logic [35:0] btb_data;
  logic [7:0]  btb_rdaddr;
  logic [35:0] btb_q;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_insn [256];
  logic [35:0] m_btb  [256];
  logic [31:0] exp_insn_q [$];
  logic [35:0] exp_btb_q  [$];

  bpred_fetch_mems dut (
    .clk           (clk),
    .reset         (reset),
    .insn_wren_i   (insn_wren),
    .insn_wraddr_i (insn_wraddr),
    .insn_data_i   (insn_data),
    .insn_rdaddr_i (insn_rdaddr),
    .insn_q_o      (insn_q),
    .btb_wren_i    (btb_wren),
    .btb_byteena_i (btb_byteena),
    .btb_wraddr_i  (btb_wraddr),
    .btb_data_i    (btb_data),
    .btb_rdaddr_i  (btb_rdaddr),
    .btb_q_o       (btb_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: queue expected reads from the pre-edge model, apply writes, then compare.
  task automatic step(input string tag);
    logic [31:0] ei;
    logic [35:0] eb;
    exp_insn_q.push_back(reset ? 32'h0 : m_insn[insn_rdaddr]);
    exp_btb_q.push_back(reset ? 36'h0 : m_btb[btb_rdaddr]);
    if (insn_wren) m_insn[insn_wraddr] = insn_data;
    if (btb_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (btb_byteena[i]) m_btb[btb_wraddr][i*9 +: 9] = btb_data[i*9 +: 9];
      end
    end
    @(posedge clk);
    #1;
    ei = exp_insn_q.pop_front();
    eb = exp_btb_q.pop_front();
    checks++;
    assert (insn_q === ei) else begin
      errors++;
      $error("FAIL %s insn_q obs=%h exp=%h", tag, insn_q, ei);
    end
    checks++;
    assert (btb_q === eb) else begin
      errors++;
      $error("FAIL %s btb_q obs=%h exp=%h", tag, btb_q, eb);
    end
  endtask

  task automatic chk_insn(input string tag, input logic [31:0] e);
    checks++;
    assert (insn_q === e) else begin
      errors++;
      $error("FAIL %s insn_q obs=%h exp=%h", tag, insn_q, e);
    end
  endtask

  task automatic chk_btb(input string tag, input logic [35:0] e);
    checks++;
    assert (btb_q === e) else begin
      errors++;
      $error("FAIL %s btb_q obs=%h exp=%h", tag, btb_q, e);
    end
  endtask

  task automatic idle_writes();
    insn_wren   = 1'b0;
    btb_wren    = 1'b0;
    btb_byteena = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_insn[i] = '0;
      m_btb[i]  = '0;
    end
    reset = 1'b1;
    insn_wren = 1'b0; insn_wraddr = '0; insn_data = '0; insn_rdaddr = '0;
    btb_wren = 1'b0; btb_byteena = '0; btb_wraddr = '0; btb_data = '0; btb_rdaddr = '0;
    #2;
    step("reset0");
    step("reset1");
    chk_insn("reset_insn", 32'h0);
    chk_btb("reset_btb", 36'h0);

    // Unwritten location reads zero.
    reset = 1'b0;
    insn_rdaddr = 8'h10; btb_rdaddr = 8'h10;
    step("zero_rd");
    chk_insn("zero_insn", 32'h0);
    chk_btb("zero_btb", 36'h0);

    insn_wren = 1'b1; insn_wraddr = 8'h05; insn_data = 32'hDEADBEEF;
    step("insn_wr");
    idle_writes();
    insn_rdaddr = 8'h05;
    step("insn_rd");
    chk_insn("insn_deadbeef", 32'hDEADBEEF);

    btb_wren = 1'b1; btb_byteena = 4'hF; btb_wraddr = 8'h22; btb_data = 36'hABCDE1234;
    step("btb_full_wr");
    btb_byteena = 4'b0001; btb_data = 36'h000000155;
    step("btb_lane0_wr");
    idle_writes();
    btb_rdaddr = 8'h22;
    step("btb_lane_rd");
    chk_btb("btb_lane0_merge", 36'hABCDE1355);

    // Enable with no lanes is a no-op.
    btb_wren = 1'b1; btb_byteena = 4'h0; btb_data = 36'hFFFFFFFFF;
    step("btb_noop_wr");
    idle_writes();
    step("btb_noop_rd");
    chk_btb("btb_noop", 36'hABCDE1355);

    // Read-during-write returns old data.
    btb_wren = 1'b1; btb_byteena = 4'hF; btb_wraddr = 8'h40; btb_data = 36'h1;
    step("rdw_init");
    btb_data = 36'h2; btb_rdaddr = 8'h40;
    step("rdw_same");
    chk_btb("rdw_old", 36'h1);
    idle_writes();
    step("rdw_next");
    chk_btb("rdw_new", 36'h2);

    insn_wren = 1'b1; insn_wraddr = 8'h05; insn_data = 32'h0BADF00D; insn_rdaddr = 8'h05;
    step("insn_rdw");
    chk_insn("insn_rdw_old", 32'hDEADBEEF);

    // Same address on both RAMs.
    insn_wraddr = 8'h80; insn_data = 32'h12345678;
    btb_wren = 1'b1; btb_byteena = 4'hF; btb_wraddr = 8'h80; btb_data = 36'hFFFFFFFFF;
    step("indep_wr");
    idle_writes();
    insn_rdaddr = 8'h80; btb_rdaddr = 8'h80;
    step("indep_rd");
    chk_insn("indep_insn", 32'h12345678);
    chk_btb("indep_btb", 36'hFFFFFFFFF);

    // Random traffic including address wrap 0xFF -> 0x00.
    for (int n = 0; n < 64; n++) begin
      insn_wren   = 1'($urandom_range(0, 1));
      insn_wraddr = (n % 8 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      insn_data   = $urandom;
      insn_rdaddr = (n % 2 == 0) ? 8'hFF : 8'h00;
      btb_wren    = 1'($urandom_range(0, 1));
      btb_byteena = 4'($urandom_range(0, 15));
      btb_wraddr  = (n % 4 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      btb_data    = {4'($urandom), 32'($urandom)};
      btb_rdaddr  = (n % 3 == 0) ? insn_wraddr : 8'($urandom_range(0, 255));
      step("random");
    end
    // Ensure word 0x22 still holds a known value for the sweep check.
    insn_wren = 1'b0;
    btb_wren = 1'b1; btb_byteena = 4'hF; btb_wraddr = 8'h22; btb_data = 36'hABCDE1355;
    step("restore22");

    // Reset sweep clears lane 0 of every BTB word while reads are forced to zero.
    reset = 1'b1;
    btb_byteena = 4'b0001; btb_data = 36'h0;
    for (int a = 0; a < 256; a++) begin
      btb_wraddr = 8'(a);
      btb_rdaddr = 8'(255 - a);
      insn_rdaddr = 8'h05;
      step("sweep");
    end
    reset = 1'b0;
    idle_writes();
    for (int a = 0; a < 256; a++) begin
      btb_rdaddr = 8'(a);
      insn_rdaddr = 8'(a);
      step("post_sweep");
      checks++;
      assert (btb_q[8:0] === 9'h0) else begin
        errors++;
        $error("FAIL post_sweep_lane0 addr=%0d obs=%h exp=000", a, btb_q[8:0]);
      end
    end
    btb_rdaddr = 8'h22;
    step("sweep22");
    chk_btb("sweep_upper_kept", 36'hABCDE1200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_fetch_mems.md
Name: bpred_fetch_mems

Overview:
- Memory macro wrapper for the branch-predictor fetch stage. Holds two independent simple-dual-port synchronous RAMs:
  - an instruction RAM, 256 x 32;
  - a combined BTB/bimodal RAM, 256 x 36, split into four 9-bit byte lanes with per-lane write enables.
- Both RAMs have one write port and one read port on clk, with a registered read.
- The fetch predictor drives the read ports with PC[9:2]. The execute/update path drives the write ports.

Parameters:
- ADDR_W, 8, address width of both RAMs.
- DEPTH, 256, words per RAM (2**ADDR_W).
- INSN_W, 32, instruction RAM word width.
- LANE_W, 9, BTB RAM byte-lane width.
- LANES, 4, BTB RAM lane count (word = LANES*LANE_W = 36).

Ports:
- clk  in  1  clock; all activity on rising edge.
- reset  in  1  synchronous, active-high reset.
- insn_wren  in  1  instruction RAM write enable.
- insn_wraddr  in  8  instruction RAM write address.
- insn_data  in  32  instruction RAM write data.
- insn_rdaddr  in  8  instruction RAM read address.
- insn_q  out  32  instruction RAM registered read data.
- btb_wren  in  1  BTB RAM write enable.
- btb_byteena  in  4  BTB RAM lane enables for the write.
- btb_wraddr  in  8  BTB RAM write address.
- btb_data  in  36  BTB RAM write data.
- btb_rdaddr  in  8  BTB RAM read address.
- btb_q  out  36  BTB RAM registered read data.

Behaviour:
- Storage: both arrays initialise to all zeros at time 0. Contents are never cleared by reset.
- Instruction RAM write: on a rising edge with insn_wren=1, mem[insn_wraddr] <= insn_data.
- BTB RAM write: on a rising edge with btb_wren=1, for each lane i where btb_byteena[i]=1, lane i of word btb_wraddr takes btb_data[9*i+8 : 9*i].
  - Lane 0 = bits [8:0], lane 1 = [17:9], lane 2 = [26:18], lane 3 = [35:27].
  - Lanes with byteena=0 keep their old value.
  - btb_byteena=4'b0000 with btb_wren=1 is a no-op.
- Reads, both RAMs: the address is sampled on the rising edge and q updates on that same edge. Read latency is 1 cycle. q holds its value until the next edge.
- Read-during-write to the same address on the same edge: q returns the OLD (pre-write) data. The new data is visible on the next read.
- Writes are always honoured, including while reset=1. The predictor clears the bimodal table by sweeping writes during reset.
- Reset: on an edge with reset=1, insn_q <= 0 and btb_q <= 0. Read addresses are ignored that cycle.
  - The first valid read data appears one edge after reset deasserts (address presented in the first cycle with reset=0).
- Reset deasserted mid-sequence: there are no pipeline bubbles beyond the single registered stage. Pending writes are unaffected.
- The two RAMs are fully independent. Identical addresses on both RAMs never interact.
- Addresses are exactly 8 bits, so there is no out-of-range case. Address 8'hFF followed by 8'h00 needs no special handling.
- No X propagation from uninitialised words: the zero init guarantees defined reads.

Test Plan:
- After reset, read insn_rdaddr=0x10 and btb_rdaddr=0x10 with no prior writes -> insn_q=0, btb_q=0 on the following edge.
- Write insn_data=0xDEADBEEF at 0x05, then read 0x05 next cycle -> insn_q=0xDEADBEEF exactly one edge after the read address is applied.
- BTB full write: btb_byteena=4'hF, data=36'hABCDE1234 at 0x22; then a lane-0 write, byteena=4'b0001, data=36'h000000155 -> read 0x22 returns 36'hABCDE1355. Only bits [8:0] change.
- Same-edge read/write: BTB address 0x40 holds 36'h1, then a write of 36'h2 while reading 0x40 -> btb_q=36'h1 that cycle, and 36'h2 on the next read.
- Reset sweep: hold reset=1, write byteena=4'b0001, data=0 to addresses 0..255 over 256 cycles -> btb_q=0 throughout reset. After reset, lane 0 of every word reads 0 and the upper lanes keep their prior contents.
- Independence: simultaneous writes to insn 0x80 (0x12345678) and btb 0x80 (36'hFFFFFFFFF), then reads of both -> each returns its own data.
